// File: rtl/bip_pkg.sv
// Shared types for the BIP execution sequencer: run/debug state encodings,
// the halt opcode and the command priority resolver.
package bip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_HALT  = 3'd4
  } run_state_e;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_READ = 2'd1,
    D_ACK  = 2'd2
  } dbg_state_e;

  localparam logic [4:0] OP_HLT_CODE = 5'b00000;

  typedef struct packed {
    logic clear;
    logic start;
    logic step;
    logic pause;
  } cmd_t;

  // Keep only the highest-priority command: clear > start > step > pause.
  function automatic cmd_t prioritize(cmd_t raw);
    cmd_t res;
    res = 4'b0000;
    if (raw.clear) begin
      res.clear = 1'b1;
    end else if (raw.start) begin
      res.start = 1'b1;
    end else if (raw.step) begin
      res.step = 1'b1;
    end else if (raw.pause) begin
      res.pause = 1'b1;
    end else begin
      res = 4'b0000;
    end
    return res;
  endfunction

endpackage

// File: rtl/bip_run_ctrl_if.sv
// Command, status and debug-read signals between the BIP sequencer and its
// surroundings; the sequencer takes the slave side.
interface bip_run_ctrl_if #(
  parameter int NB_OPCODE = 5,
  parameter int NB_ADDR   = 11,
  parameter int NB_DATA   = 16,
  parameter int NB_CYCLES = 16
);
  logic                 i_start;
  logic                 i_step;
  logic                 i_pause;
  logic                 i_clear;
  logic [NB_OPCODE-1:0] i_opcode;
  logic                 o_cpu_en;
  logic                 o_cpu_clr;
  logic [2:0]           o_state;
  logic [NB_CYCLES-1:0] o_cycles;
  logic                 i_dbg_req;
  logic [NB_ADDR-1:0]   i_dbg_addr;
  logic                 o_dbg_ack;
  logic [NB_DATA-1:0]   o_dbg_data;
  logic                 o_mem_sel;
  logic [NB_ADDR-1:0]   o_mem_addr;
  logic [NB_DATA-1:0]   i_mem_data;

  modport master (
    output i_start, i_step, i_pause, i_clear, i_opcode,
    output i_dbg_req, i_dbg_addr, i_mem_data,
    input  o_cpu_en, o_cpu_clr, o_state, o_cycles,
    input  o_dbg_ack, o_dbg_data, o_mem_sel, o_mem_addr
  );

  modport slave (
    input  i_start, i_step, i_pause, i_clear, i_opcode,
    input  i_dbg_req, i_dbg_addr, i_mem_data,
    output o_cpu_en, o_cpu_clr, o_state, o_cycles,
    output o_dbg_ack, o_dbg_data, o_mem_sel, o_mem_addr
  );

endinterface

// File: rtl/bip_dbg_port.sv
// Debug read port: grants the data-memory read port to the debug requester
// for one cycle and returns the captured word with a one-cycle ack.
module bip_dbg_port
  import bip_pkg::*;
#(
  parameter int NB_ADDR = 11,
  parameter int NB_DATA = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               grant_ok,
  input  logic               req,
  input  logic [NB_ADDR-1:0] addr,
  input  logic [NB_DATA-1:0] mem_data,
  output logic               busy,
  output logic               acking,
  output logic               ack,
  output logic [NB_DATA-1:0] data,
  output logic               mem_sel,
  output logic [NB_ADDR-1:0] mem_addr
);

  dbg_state_e         dstate_r;
  dbg_state_e         dstate_next_s;
  logic               grant_s;
  logic               ack_r;
  logic [NB_DATA-1:0] data_r;
  logic [NB_ADDR-1:0] addr_r;

  assign grant_s = (dstate_r == D_IDLE) && req && grant_ok;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dstate_r <= D_IDLE;
    end else begin
      dstate_r <= dstate_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    dstate_next_s = D_IDLE;
    case (dstate_r)
      D_IDLE:  dstate_next_s = grant_s ? D_READ : D_IDLE;
      D_READ:  dstate_next_s = D_ACK;
      D_ACK:   dstate_next_s = D_IDLE;
      default: dstate_next_s = D_IDLE;
    endcase
  end

  // Address is held only for the D_READ cycle, so it drops back to zero with the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= {NB_ADDR{1'b0}};
      ack_r  <= 1'b0;
      data_r <= {NB_DATA{1'b0}};
    end else begin
      addr_r <= grant_s ? addr : {NB_ADDR{1'b0}};
      ack_r  <= (dstate_r == D_READ);
      if (dstate_r == D_READ) begin
        data_r <= mem_data;
      end else begin
        data_r <= data_r;
      end
    end
  end

  // Outputs decoded from the registered debug state
  always_comb begin
    mem_sel = 1'b0;
    busy    = 1'b1;
    acking  = 1'b0;
    case (dstate_r)
      D_IDLE:  busy    = 1'b0;
      D_READ:  mem_sel = 1'b1;
      D_ACK:   acking  = 1'b1;
      default: busy    = 1'b0;
    endcase
  end

  assign ack      = ack_r;
  assign data     = data_r;
  assign mem_addr = addr_r;

endmodule

// File: rtl/bip_run_ctrl.sv
// BIP execution sequencer: run/step/pause/clear control, halt detection,
// executed-instruction counter and data-memory read-port arbitration.
module bip_run_ctrl
  import bip_pkg::*;
#(
  parameter int                   NB_OPCODE = 5,
  parameter int                   NB_ADDR   = 11,
  parameter int                   NB_DATA   = 16,
  parameter int                   NB_CYCLES = 16,
  parameter logic [NB_OPCODE-1:0] OP_HLT    = OP_HLT_CODE
) (
  input logic           i_clk,
  input logic           i_rst,
  bip_run_ctrl_if.slave bus
);

  run_state_e           state_r;
  run_state_e           next_state_s;
  logic                 pend_start_r;
  logic                 pend_step_r;
  logic [NB_CYCLES-1:0] cycles_r;
  logic                 dbg_busy_s;
  logic                 dbg_acking_s;
  logic                 grant_ok_s;
  logic                 is_hlt_s;
  logic                 cpu_en_s;
  logic                 cpu_clr_s;
  cmd_t                 raw_s;
  cmd_t                 cmd_s;

  assign is_hlt_s = (bus.i_opcode == OP_HLT);

  // Start/step are held off while a debug read owns the port and replayed on its ack cycle.
  always_comb begin
    raw_s.clear = bus.i_clear;
    raw_s.pause = bus.i_pause;
    if (dbg_acking_s) begin
      raw_s.start = bus.i_start | pend_start_r;
      raw_s.step  = bus.i_step | pend_step_r;
    end else if (dbg_busy_s) begin
      raw_s.start = 1'b0;
      raw_s.step  = 1'b0;
    end else begin
      raw_s.start = bus.i_start;
      raw_s.step  = bus.i_step;
    end
    cmd_s = prioritize(raw_s);
  end

  // Pending command bits
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_start_r <= 1'b0;
      pend_step_r  <= 1'b0;
    end else if (bus.i_clear) begin
      pend_start_r <= 1'b0;
      pend_step_r  <= 1'b0;
    end else if (dbg_busy_s && !dbg_acking_s) begin
      pend_start_r <= pend_start_r | bus.i_start;
      pend_step_r  <= pend_step_r | bus.i_step;
    end else begin
      pend_start_r <= 1'b0;
      pend_step_r  <= 1'b0;
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    if (cmd_s.clear) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_s.start) begin
            next_state_s = ST_RUN;
          end else if (cmd_s.step) begin
            next_state_s = ST_STEP;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (is_hlt_s) begin
            next_state_s = ST_HALT;
          end else if (cmd_s.pause) begin
            next_state_s = ST_PAUSE;
          end else begin
            next_state_s = ST_RUN;
          end
        end
        ST_STEP: next_state_s = is_hlt_s ? ST_HALT : ST_PAUSE;
        ST_PAUSE: begin
          if (cmd_s.start) begin
            next_state_s = ST_RUN;
          end else if (cmd_s.step) begin
            next_state_s = ST_STEP;
          end else begin
            next_state_s = ST_PAUSE;
          end
        end
        ST_HALT: next_state_s = ST_HALT;
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // Output logic; debug grant also refused when this edge starts execution
  always_comb begin
    cpu_en_s   = 1'b0;
    cpu_clr_s  = 1'b0;
    grant_ok_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cpu_clr_s  = 1'b1;
        grant_ok_s = 1'b1;
      end
      ST_RUN:   cpu_en_s   = !is_hlt_s;
      ST_STEP:  cpu_en_s   = !is_hlt_s;
      ST_PAUSE: grant_ok_s = 1'b1;
      ST_HALT:  grant_ok_s = 1'b1;
      default:  cpu_clr_s  = 1'b1;
    endcase
    if ((next_state_s == ST_RUN) || (next_state_s == ST_STEP)) begin
      grant_ok_s = 1'b0;
    end else begin
      grant_ok_s = grant_ok_s;
    end
  end

  // Executed-instruction counter, saturating, zeroed in IDLE and on clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cycles_r <= {NB_CYCLES{1'b0}};
    end else if (bus.i_clear || (state_r == ST_IDLE)) begin
      cycles_r <= {NB_CYCLES{1'b0}};
    end else if (cpu_en_s && (cycles_r != {NB_CYCLES{1'b1}})) begin
      cycles_r <= cycles_r + {{(NB_CYCLES-1){1'b0}}, 1'b1};
    end else begin
      cycles_r <= cycles_r;
    end
  end

  bip_dbg_port #(
    .NB_ADDR (NB_ADDR),
    .NB_DATA (NB_DATA)
  ) u_dbg_port (
    .clk      (i_clk),
    .rst      (i_rst),
    .grant_ok (grant_ok_s),
    .req      (bus.i_dbg_req),
    .addr     (bus.i_dbg_addr),
    .mem_data (bus.i_mem_data),
    .busy     (dbg_busy_s),
    .acking   (dbg_acking_s),
    .ack      (bus.o_dbg_ack),
    .data     (bus.o_dbg_data),
    .mem_sel  (bus.o_mem_sel),
    .mem_addr (bus.o_mem_addr)
  );

  assign bus.o_cpu_en  = cpu_en_s;
  assign bus.o_cpu_clr = cpu_clr_s;
  assign bus.o_state   = state_r;
  assign bus.o_cycles  = cycles_r;

endmodule

// File: tb/tb_bip_run_ctrl.sv
// Directed bench for bip_run_ctrl; debug-read results are checked through a
// scoreboard queue filled when each request is issued.
module tb_bip_run_ctrl;

  localparam int NB_OPCODE = 5;
  localparam int NB_ADDR   = 11;
  localparam int NB_DATA   = 16;
  localparam int NB_CYCLES = 4;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] sb[$];

  bip_run_ctrl_if #(
    .NB_OPCODE (NB_OPCODE),
    .NB_ADDR   (NB_ADDR),
    .NB_DATA   (NB_DATA),
    .NB_CYCLES (NB_CYCLES)
  ) bus ();

  bip_run_ctrl #(
    .NB_OPCODE (NB_OPCODE),
    .NB_ADDR   (NB_ADDR),
    .NB_DATA   (NB_DATA),
    .NB_CYCLES (NB_CYCLES),
    .OP_HLT    (5'b00000)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] mem_word(logic [10:0] a);
    return (a == 11'h010) ? 16'hBEEF : ({5'b00000, a} ^ 16'hA5A5);
  endfunction

  always_comb bus.i_mem_data = bus.o_mem_sel ? mem_word(bus.o_mem_addr) : 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic take_ack(input string tag);
    logic [15:0] e;
    check({tag, "_ack"}, bus.o_dbg_ack, 1);
    check({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, bus.o_dbg_data, e);
    end
  endtask

  // CPU writes and debug port ownership must never coincide
  always @(negedge i_clk) begin
    if (!i_rst) begin
      n_cmp++;
      assert (!(bus.o_cpu_en && bus.o_mem_sel)) else begin
        n_err++;
        $error("FAIL overlap observed cpu_en=%0b mem_sel=%0b expected not both 1", bus.o_cpu_en, bus.o_mem_sel);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start    = 1'b0;
    bus.i_step     = 1'b0;
    bus.i_pause    = 1'b0;
    bus.i_clear    = 1'b0;
    bus.i_opcode   = 5'h03;
    bus.i_dbg_req  = 1'b0;
    bus.i_dbg_addr = 11'h000;
    #1;
    check("rst_state", bus.o_state, 0);
    check("rst_cpu_clr", bus.o_cpu_clr, 1);
    check("rst_cpu_en", bus.o_cpu_en, 0);
    check("rst_cycles", bus.o_cycles, 0);
    check("rst_ack", bus.o_dbg_ack, 0);
    check("rst_data", bus.o_dbg_data, 0);
    check("rst_mem_sel", bus.o_mem_sel, 0);
    check("rst_mem_addr", bus.o_mem_addr, 0);
    tick();
    i_rst = 1'b0;
    tick();
    check("idle_state", bus.o_state, 0);

    // Run to halt: 03, 05, then HLT
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check("run_state", bus.o_state, 1);
    check("run_en0", bus.o_cpu_en, 1);
    check("run_cyc0", bus.o_cycles, 0);
    tick();
    bus.i_opcode = 5'h05;
    check("run_en1", bus.o_cpu_en, 1);
    check("run_cyc1", bus.o_cycles, 1);
    tick();
    bus.i_opcode = 5'h00;
    #1;
    check("hlt_cycle_en", bus.o_cpu_en, 0);
    check("hlt_cycle_state", bus.o_state, 1);
    check("hlt_cycle_cyc", bus.o_cycles, 2);
    tick();
    check("halt_state", bus.o_state, 4);
    check("halt_cycles", bus.o_cycles, 2);
    check("halt_en", bus.o_cpu_en, 0);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check("halt_sticky", bus.o_state, 4);

    // Debug read granted in HALT
    bus.i_dbg_req  = 1'b1;
    bus.i_dbg_addr = 11'h005;
    sb.push_back(mem_word(11'h005));
    tick();
    check("halt_rd_sel", bus.o_mem_sel, 1);
    check("halt_rd_addr", bus.o_mem_addr, 11'h005);
    tick();
    take_ack("halt_rd");
    bus.i_dbg_req = 1'b0;
    tick();
    check("halt_rd_ack_off", bus.o_dbg_ack, 0);
    check("halt_rd_sel_off", bus.o_mem_sel, 0);
    check("halt_rd_addr_off", bus.o_mem_addr, 0);

    // Single step twice
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    check("clr_state", bus.o_state, 0);
    check("clr_cycles", bus.o_cycles, 0);
    check("clr_cpu_clr", bus.o_cpu_clr, 1);
    bus.i_opcode = 5'h07;
    for (int k = 0; k < 2; k++) begin
      bus.i_step = 1'b1;
      tick();
      bus.i_step = 1'b0;
      check("step_state", bus.o_state, 2);
      check("step_en", bus.o_cpu_en, 1);
      tick();
      check("step_pause", bus.o_state, 3);
      check("step_en_off", bus.o_cpu_en, 0);
      check("step_cycles", bus.o_cycles, k + 1);
    end

    // Debug request blocked during RUN
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear  = 1'b0;
    bus.i_opcode = 5'h03;
    bus.i_start  = 1'b1;
    tick();
    bus.i_start    = 1'b0;
    bus.i_dbg_req  = 1'b1;
    bus.i_dbg_addr = 11'h010;
    sb.push_back(16'hBEEF);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("blk_ack", bus.o_dbg_ack, 0);
      check("blk_sel", bus.o_mem_sel, 0);
    end
    bus.i_pause = 1'b1;
    tick();
    bus.i_pause = 1'b0;
    check("blk_paused", bus.o_state, 3);
    check("blk_sel_pause", bus.o_mem_sel, 0);
    tick();
    check("blk_grant_sel", bus.o_mem_sel, 1);
    check("blk_grant_addr", bus.o_mem_addr, 11'h010);
    check("blk_grant_en", bus.o_cpu_en, 0);
    tick();
    take_ack("blk_rd");
    bus.i_dbg_req = 1'b0;
    tick();
    check("blk_ack_off", bus.o_dbg_ack, 0);

    // Start while the debug FSM is in D_READ
    bus.i_dbg_req  = 1'b1;
    bus.i_dbg_addr = 11'h020;
    sb.push_back(16'hA585);
    tick();
    check("pend_sel", bus.o_mem_sel, 1);
    bus.i_start = 1'b1;
    tick();
    bus.i_start   = 1'b0;
    bus.i_dbg_req = 1'b0;
    check("pend_state_hold", bus.o_state, 3);
    take_ack("pend_rd");
    check("pend_ack_en", bus.o_cpu_en, 0);
    tick();
    check("pend_run", bus.o_state, 1);
    check("pend_run_en", bus.o_cpu_en, 1);
    check("pend_run_sel", bus.o_mem_sel, 0);

    // Reset mid-run with 7 instructions counted
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (7) tick();
    check("pre_rst_cycles", bus.o_cycles, 7);
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_en", bus.o_cpu_en, 0);
    check("arst_clr", bus.o_cpu_clr, 1);
    check("arst_cycles", bus.o_cycles, 0);
    check("arst_state", bus.o_state, 0);
    tick();
    i_rst = 1'b0;

    // Reset aborts an in-flight debug read without an ack
    bus.i_dbg_req  = 1'b1;
    bus.i_dbg_addr = 11'h030;
    sb.push_back(mem_word(11'h030));
    tick();
    check("abort_sel", bus.o_mem_sel, 1);
    #2;
    i_rst = 1'b1;
    bus.i_dbg_req = 1'b0;
    #1;
    sb.delete();
    check("abort_sel_off", bus.o_mem_sel, 0);
    check("abort_addr_off", bus.o_mem_addr, 0);
    check("abort_ack", bus.o_dbg_ack, 0);
    tick();
    i_rst = 1'b0;
    tick();
    check("abort_no_ack", bus.o_dbg_ack, 0);

    // Counter saturation at 4 bits, then clear
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (20) tick();
    check("sat_cycles", bus.o_cycles, 15);
    check("sat_state", bus.o_state, 1);
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    check("sat_clr_cycles", bus.o_cycles, 0);
    check("sat_clr_state", bus.o_state, 0);

    // Priority: start beats step, clear beats start
    bus.i_start = 1'b1;
    bus.i_step  = 1'b1;
    tick();
    bus.i_step = 1'b0;
    check("prio_start", bus.o_state, 1);
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    bus.i_start = 1'b0;
    check("prio_clear", bus.o_state, 0);

    // Step onto HLT goes to HALT without enabling
    bus.i_opcode = 5'h00;
    bus.i_step   = 1'b1;
    tick();
    bus.i_step = 1'b0;
    check("step_hlt_state", bus.o_state, 2);
    check("step_hlt_en", bus.o_cpu_en, 0);
    tick();
    check("step_hlt_halt", bus.o_state, 4);
    check("step_hlt_cycles", bus.o_cycles, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
